retire_trace: RTL and testbench
===============================

RETIRE_TRACE -- requirements
Module: retire_trace

Interface
REQ-001 SHALL provide parameter IQ_DEPTH, default 4: in-flight (issued, not yet executed) entries, power of two.
REQ-002 SHALL provide parameter OQ_DEPTH, default 8: retire-record output FIFO entries, power of two.
REQ-003 SHALL have ports, one per line:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low.
- iss_v  input  1  instruction issued from fetch stage this cycle.
- iss_pc  input  32  pc of issued instruction.
- iss_inst  input  32  instruction word.
- ex_v  input  1  oldest in-flight instruction completes execute this cycle.
- ex_rd_v  input  1  execute writes a register.
- ex_rd  input  5  destination register index.
- ex_rd_data  input  32  write-back data.
- pass_pc  input  32  retire pc signalling test pass.
- fail_pc  input  32  retire pc signalling test fail.
- rt_valid  output  1  retire record available.
- rt_ready  input  1  sink accepts record.
- rt_pc  output  32  record pc.
- rt_inst  output  32  record instruction.
- rt_rd_v  output  1  record has register write.
- rt_rd  output  5  record destination index.
- rt_rd_data  output  32  record write-back data.
- rt_seq  output  32  record sequence number.
- retire_cnt  output  32  instructions retired.
- done  output  1  sticky, pass_pc or fail_pc retired.
- pass  output  1  sticky, valid when done.
- err_under  output  1  sticky, ex_v with no in-flight instruction.
- err_over  output  1  sticky, in-flight or output queue overflow.

Function
REQ-004 SHALL push {iss_pc, iss_inst} into in-flight queue (IQ) on iss_v.
REQ-005 SHALL on ex_v pop oldest IQ entry and form record {pc, inst, ex_rd_v & (ex_rd!=0), ex_rd, ex_rd_data, seq=retire_cnt}.
REQ-006 SHALL, when IQ empty and iss_v and ex_v same cycle, bypass: record uses this cycle's iss_pc/iss_inst; IQ stays empty.
REQ-007 SHALL, when IQ non-empty and iss_v and ex_v same cycle, push and pop together; occupancy unchanged, no overflow even if full.
REQ-008 SHALL, on ex_v with IQ empty and no iss_v, set err_under, form no record, leave retire_cnt unchanged.
REQ-009 SHALL, on iss_v with IQ full and no ex_v, drop the issue and set err_over.
REQ-010 SHALL increment retire_cnt by 1 (mod 2^32) per formed record, including records later dropped by REQ-012.
REQ-011 SHALL write each formed record into output queue (OQ); rt_valid asserts the cycle after ex_v when OQ was empty (latency 1).
REQ-012 SHALL, when record formed and OQ full with no pop that cycle, drop record and set err_over; full OQ with simultaneous pop accepts it.
REQ-013 SHALL pop OQ on rt_valid & rt_ready; rt_* fields hold stable while rt_valid & !rt_ready.
REQ-014 SHALL, when formed record pc == fail_pc, set done=1, pass=0; else if == pass_pc, set done=1, pass=1; fail takes priority if equal.
REQ-015 SHALL, once done=1, ignore iss_v and ex_v (no records, counters frozen); OQ continues to drain.
REQ-016 SHALL wrap IQ/OQ pointers modulo depth; occupancy counters span 0..DEPTH.

Reset
REQ-017 SHALL, while reset=0 at clock edge, clear IQ, OQ, retire_cnt=0, rt_valid=0, done=0, pass=0, err_under=0, err_over=0; rt_* data outputs 0.
REQ-018 SHALL apply reset mid-operation with priority over all inputs that cycle; in-flight and queued records discarded.

Verification
REQ-019 Issue pc 0x100 inst 0x00500093, next cycle ex_v rd=1 data=5 -> one cycle later rt_valid, rt_pc=0x100, rt_rd_v=1, rt_rd=1, rt_rd_data=5, rt_seq=0, retire_cnt=1.
REQ-020 Empty IQ, iss_v pc 0x200 with ex_v rd=0 same cycle -> record pc 0x200, rt_rd_v=0, IQ empty after.
REQ-021 rt_ready=0, 9 retires with OQ_DEPTH=8 -> 8 records held, err_over=1, retire_cnt=9; then rt_ready=1 drains seq 0..7 in order.
REQ-022 ex_v with IQ empty, no iss_v -> err_under=1, no record, retire_cnt unchanged; 5 issues with IQ_DEPTH=4, no ex_v -> err_over=1, 4 entries.
REQ-023 pass_pc=0x1000, retire pc 0x1000 -> done=1, pass=1; further ex_v ignored; pass_pc=fail_pc=0x1000 -> pass=0.
REQ-024 reset=0 with 3 queued records -> next cycle rt_valid=0, retire_cnt=0, all flags 0.

Source files
------------

// File: rtl/retire_trace.sv
// Retire trace collector: pairs issued instructions with execute completions,
// produces sequenced retire records into an output FIFO and tracks pass/fail.
module retire_trace #(
  parameter int IQ_DEPTH = 4,
  parameter int OQ_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iss_v,
  input  logic [31:0] iss_pc,
  input  logic [31:0] iss_inst,
  input  logic        ex_v,
  input  logic        ex_rd_v,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_rd_data,
  input  logic [31:0] pass_pc,
  input  logic [31:0] fail_pc,
  output logic        rt_valid,
  input  logic        rt_ready,
  output logic [31:0] rt_pc,
  output logic [31:0] rt_inst,
  output logic        rt_rd_v,
  output logic [4:0]  rt_rd,
  output logic [31:0] rt_rd_data,
  output logic [31:0] rt_seq,
  output logic [31:0] retire_cnt,
  output logic        done,
  output logic        pass,
  output logic        err_under,
  output logic        err_over
);

  localparam int IAW = $clog2(IQ_DEPTH);
  localparam int ICW = $clog2(IQ_DEPTH + 1);
  localparam int OAW = $clog2(OQ_DEPTH);
  localparam int OCW = $clog2(OQ_DEPTH + 1);
  localparam logic [ICW-1:0] IQ_MAX = ICW'(IQ_DEPTH);
  localparam logic [OCW-1:0] OQ_MAX = OCW'(OQ_DEPTH);

  logic [31:0]    iq_pc   [IQ_DEPTH];
  logic [31:0]    iq_inst [IQ_DEPTH];
  logic [IAW-1:0] iq_wptr, iq_rptr;
  logic [ICW-1:0] iq_cnt;

  logic [31:0]    oq_pc      [OQ_DEPTH];
  logic [31:0]    oq_inst    [OQ_DEPTH];
  logic           oq_rd_v    [OQ_DEPTH];
  logic [4:0]     oq_rd      [OQ_DEPTH];
  logic [31:0]    oq_rd_data [OQ_DEPTH];
  logic [31:0]    oq_seq     [OQ_DEPTH];
  logic [OAW-1:0] oq_wptr, oq_rptr;
  logic [OCW-1:0] oq_cnt;

  logic        iq_push, iq_pop, iq_over, under;
  logic        rec_v, rec_rd_v;
  logic [31:0] rec_pc, rec_inst;
  logic        oq_push, oq_pop, oq_over;

  // A record comes from the IQ head, or straight from the issue port when the
  // IQ is empty and issue/execute coincide (bypass keeps the IQ empty).
  always_comb begin
    rec_v    = 1'b0;
    rec_pc   = '0;
    rec_inst = '0;
    iq_push  = 1'b0;
    iq_pop   = 1'b0;
    iq_over  = 1'b0;
    under    = 1'b0;
    if (!done) begin
      if (ex_v) begin
        if (iq_cnt != '0) begin
          rec_v    = 1'b1;
          rec_pc   = iq_pc[iq_rptr];
          rec_inst = iq_inst[iq_rptr];
          iq_pop   = 1'b1;
          iq_push  = iss_v;
        end else if (iss_v) begin
          rec_v    = 1'b1;
          rec_pc   = iss_pc;
          rec_inst = iss_inst;
        end else begin
          under = 1'b1;
        end
      end else if (iss_v) begin
        if (iq_cnt == IQ_MAX) iq_over = 1'b1;
        else                  iq_push = 1'b1;
      end
    end
    rec_rd_v = ex_rd_v && (ex_rd != 5'd0);
    oq_pop   = rt_valid && rt_ready;
    oq_push  = rec_v && ((oq_cnt != OQ_MAX) || oq_pop);
    oq_over  = rec_v && (oq_cnt == OQ_MAX) && !oq_pop;
  end

  always_ff @(posedge clk) begin
    if (iq_push) begin
      iq_pc[iq_wptr]   <= iss_pc;
      iq_inst[iq_wptr] <= iss_inst;
    end
    if (oq_push) begin
      oq_pc[oq_wptr]      <= rec_pc;
      oq_inst[oq_wptr]    <= rec_inst;
      oq_rd_v[oq_wptr]    <= rec_rd_v;
      oq_rd[oq_wptr]      <= ex_rd;
      oq_rd_data[oq_wptr] <= ex_rd_data;
      oq_seq[oq_wptr]     <= retire_cnt;
    end
  end

  // Sequence numbers advance for every formed record, even ones dropped on overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      iq_wptr    <= '0;
      iq_rptr    <= '0;
      iq_cnt     <= '0;
      oq_wptr    <= '0;
      oq_rptr    <= '0;
      oq_cnt     <= '0;
      retire_cnt <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_under  <= 1'b0;
      err_over   <= 1'b0;
    end else begin
      if (iq_push) iq_wptr <= iq_wptr + IAW'(1);
      if (iq_pop)  iq_rptr <= iq_rptr + IAW'(1);
      if (iq_push && !iq_pop)      iq_cnt <= iq_cnt + ICW'(1);
      else if (iq_pop && !iq_push) iq_cnt <= iq_cnt - ICW'(1);
      if (oq_push) oq_wptr <= oq_wptr + OAW'(1);
      if (oq_pop)  oq_rptr <= oq_rptr + OAW'(1);
      if (oq_push && !oq_pop)      oq_cnt <= oq_cnt + OCW'(1);
      else if (oq_pop && !oq_push) oq_cnt <= oq_cnt - OCW'(1);
      if (rec_v) begin
        retire_cnt <= retire_cnt + 32'd1;
        if (rec_pc == fail_pc) begin
          done <= 1'b1;
          pass <= 1'b0;
        end else if (rec_pc == pass_pc) begin
          done <= 1'b1;
          pass <= 1'b1;
        end
      end
      if (under)              err_under <= 1'b1;
      if (iq_over || oq_over) err_over  <= 1'b1;
    end
  end

  assign rt_valid   = (oq_cnt != '0);
  assign rt_pc      = rt_valid ? oq_pc[oq_rptr]      : '0;
  assign rt_inst    = rt_valid ? oq_inst[oq_rptr]    : '0;
  assign rt_rd_v    = rt_valid ? oq_rd_v[oq_rptr]    : 1'b0;
  assign rt_rd      = rt_valid ? oq_rd[oq_rptr]      : '0;
  assign rt_rd_data = rt_valid ? oq_rd_data[oq_rptr] : '0;
  assign rt_seq     = rt_valid ? oq_seq[oq_rptr]     : '0;

endmodule

// File: tb/tb_retire_trace.sv
// Testbench for retire_trace: directed scenarios then random traffic, checked
// against a queue-based reference model of the retire rules.
module tb_retire_trace;

  localparam int IQ_DEPTH = 4;
  localparam int OQ_DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        iss_v = 1'b0;
  logic [31:0] iss_pc = '0, iss_inst = '0;
  logic        ex_v = 1'b0, ex_rd_v = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_rd_data = '0;
  logic [31:0] pass_pc = 32'hFFFF_0000, fail_pc = 32'hFFFF_0004;
  logic        rt_valid, rt_ready = 1'b0;
  logic [31:0] rt_pc, rt_inst, rt_rd_data, rt_seq, retire_cnt;
  logic        rt_rd_v;
  logic [4:0]  rt_rd;
  logic        done, pass, err_under, err_over;

  retire_trace #(.IQ_DEPTH(IQ_DEPTH), .OQ_DEPTH(OQ_DEPTH)) dut (
    .clk(clk), .reset(reset), .iss_v(iss_v), .iss_pc(iss_pc), .iss_inst(iss_inst),
    .ex_v(ex_v), .ex_rd_v(ex_rd_v), .ex_rd(ex_rd), .ex_rd_data(ex_rd_data),
    .pass_pc(pass_pc), .fail_pc(fail_pc), .rt_valid(rt_valid), .rt_ready(rt_ready),
    .rt_pc(rt_pc), .rt_inst(rt_inst), .rt_rd_v(rt_rd_v), .rt_rd(rt_rd),
    .rt_rd_data(rt_rd_data), .rt_seq(rt_seq), .retire_cnt(retire_cnt), .done(done),
    .pass(pass), .err_under(err_under), .err_over(err_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, inst;
    logic        rd_v;
    logic [4:0]  rd;
    logic [31:0] data, seq;
  } rec_t;

  logic [63:0] iq_q[$];
  rec_t        oq_q[$];
  logic [31:0] m_cnt;
  logic        m_done, m_pass, m_under, m_over;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference: apply one cycle of the retire rules to the model queues.
  task automatic modelStep();
    rec_t r;
    bit   formed = 0;
    if (!reset) begin
      iq_q.delete(); oq_q.delete();
      m_cnt = 0; m_done = 0; m_pass = 0; m_under = 0; m_over = 0;
      return;
    end
    if (!m_done) begin
      if (ex_v && iq_q.size() > 0) begin
        {r.pc, r.inst} = iq_q.pop_front();
        formed = 1;
        if (iss_v) iq_q.push_back({iss_pc, iss_inst});
      end else if (ex_v && iss_v) begin
        r.pc = iss_pc; r.inst = iss_inst; formed = 1;
      end else if (ex_v) begin
        m_under = 1;
      end else if (iss_v) begin
        if (iq_q.size() == IQ_DEPTH) m_over = 1;
        else iq_q.push_back({iss_pc, iss_inst});
      end
    end
    if (oq_q.size() > 0 && rt_ready) void'(oq_q.pop_front());
    if (formed) begin
      r.rd_v = ex_rd_v && (ex_rd != 0);
      r.rd = ex_rd; r.data = ex_rd_data; r.seq = m_cnt;
      m_cnt = m_cnt + 1;
      if (r.pc == fail_pc) begin m_done = 1; m_pass = 0; end
      else if (r.pc == pass_pc) begin m_done = 1; m_pass = 1; end
      if (oq_q.size() < OQ_DEPTH) oq_q.push_back(r);
      else m_over = 1;
    end
  endtask

  task automatic checkOutput();
    check("rt_valid", 32'(rt_valid), 32'(oq_q.size() > 0));
    if (oq_q.size() > 0) begin
      check("rt_pc", rt_pc, oq_q[0].pc);
      check("rt_inst", rt_inst, oq_q[0].inst);
      check("rt_rd_v", 32'(rt_rd_v), 32'(oq_q[0].rd_v));
      check("rt_rd", 32'(rt_rd), 32'(oq_q[0].rd));
      check("rt_rd_data", rt_rd_data, oq_q[0].data);
      check("rt_seq", rt_seq, oq_q[0].seq);
    end else begin
      check("rt_pc_idle", rt_pc, 32'd0);
      check("rt_seq_idle", rt_seq, 32'd0);
      check("rt_rd_v_idle", 32'(rt_rd_v), 32'd0);
    end
    check("retire_cnt", retire_cnt, m_cnt);
    check("done", 32'(done), 32'(m_done));
    check("pass", 32'(pass), 32'(m_pass));
    check("err_under", 32'(err_under), 32'(m_under));
    check("err_over", 32'(err_over), 32'(m_over));
  endtask

  task automatic applyStimulus(input logic i_v, input logic [31:0] pc, input logic [31:0] inst,
                               input logic e_v, input logic rdv, input logic [4:0] rd,
                               input logic [31:0] data, input logic rdy, input logic rst_n);
    iss_v = i_v; iss_pc = pc; iss_inst = inst;
    ex_v = e_v; ex_rd_v = rdv; ex_rd = rd; ex_rd_data = data;
    rt_ready = rdy; reset = rst_n;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset_cnt", retire_cnt, 32'd0);

    // Issue then execute: record visible one cycle after ex_v.
    applyStimulus(1, 32'h100, 32'h0050_0093, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 1, 5'd1, 32'd5, 0, 1);
    check("r19_valid", 32'(rt_valid), 32'd1);
    check("r19_pc", rt_pc, 32'h100);
    check("r19_rd", 32'(rt_rd), 32'd1);
    check("r19_data", rt_rd_data, 32'd5);
    check("r19_seq", rt_seq, 32'd0);
    check("r19_cnt", retire_cnt, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);

    // Bypass with rd=0; the following lone ex_v must underflow.
    applyStimulus(1, 32'h200, 32'h13, 1, 1, 5'd0, 32'h77, 0, 1);
    check("r20_pc", rt_pc, 32'h200);
    check("r20_rd_v", 32'(rt_rd_v), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, 1);
    check("r22_under", 32'(err_under), 32'd1);
    check("r22_cnt", retire_cnt, 32'd2);

    // Output FIFO overflow, then in-order drain.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++)
      applyStimulus(1, 32'h300 + 32'(4 * k), 32'hA000 + 32'(k), 1, 1, 5'd3, 32'(k), 0, 1);
    check("r21_cnt", retire_cnt, 32'd9);
    check("r21_over", 32'(err_over), 32'd1);
    for (int k = 0; k < 8; k++) begin
      check("r21_seq", rt_seq, 32'(k));
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
    end
    check("r21_empty", 32'(rt_valid), 32'd0);

    // In-flight queue overflow, then retire the four held entries.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      applyStimulus(1, 32'h400 + 32'(4 * k), 32'(k), 0, 0, 0, 0, 1, 1);
    check("r22_over", 32'(err_over), 32'd1);
    for (int k = 0; k < 4; k++)
      applyStimulus(0, 0, 0, 1, 1, 5'd7, 32'(k), 1, 1);
    check("r22_cnt4", retire_cnt, 32'd4);
    check("r22_no_under", 32'(err_under), 32'd0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, 1);
    check("r22_under2", 32'(err_under), 32'd1);

    // Pass detection, freeze after done, fail priority.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    pass_pc = 32'h1000;
    applyStimulus(1, 32'h1000, 32'h1, 1, 0, 0, 0, 0, 1);
    check("r23_done", 32'(done), 32'd1);
    check("r23_pass", 32'(pass), 32'd1);
    applyStimulus(1, 32'h2000, 32'h2, 1, 0, 0, 0, 1, 1);
    check("r23_frozen", retire_cnt, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    fail_pc = 32'h1000;
    applyStimulus(1, 32'h1000, 32'h1, 1, 0, 0, 0, 0, 1);
    check("r23_fail", 32'(pass), 32'd0);
    pass_pc = 32'hFFFF_0000; fail_pc = 32'hFFFF_0004;

    // Mid-operation reset discards queued records.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      applyStimulus(1, 32'h500 + 32'(4 * k), 32'(k), 1, 1, 5'd2, 32'(k), 0, 1);
    applyStimulus(1, 32'h600, 0, 1, 0, 0, 0, 0, 0);
    check("r24_valid", 32'(rt_valid), 32'd0);
    check("r24_cnt", retire_cnt, 32'd0);

    // Random traffic; pass/fail pcs are rare hits in a small pc space.
    pass_pc = 32'h3FC; fail_pc = 32'h3F8;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 800; i++)
      applyStimulus($urandom_range(0, 9) < 6, {22'd0, 8'($urandom_range(0, 255)), 2'b00},
                    $urandom, $urandom_range(0, 9) < 5, $urandom_range(0, 1) == 1,
                    5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 99) != 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
